// File: rtl/aes_pkg.sv
// Shared AES control definitions: FSM state encoding, round count, key-store address width.
package aes_pkg;
  localparam int NR     = 10;
  localparam int KEY_AW = 4;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_KEY_EXP  = 3'd1,
    ST_INIT_ARK = 3'd2,
    ST_INV_RND  = 3'd3,
    ST_LAST_RND = 3'd4,
    ST_FINISH   = 3'd5
  } state_e;
endpackage

// File: rtl/inv_cipher_fsm.sv
// AES-128 inverse cipher sequencer: optional forward key expansion into the key store,
// then initial AddRoundKey, nine inverse rounds and a final round, with Moore outputs.
module inv_cipher_fsm
  import aes_pkg::*;
(
  input  logic              CLK,
  input  logic              rst_n,
  input  logic              Valid,
  input  logic              Key_Reuse,
  input  logic              Key_Inval,
  output logic              En_KeyExp,
  output logic              Key_Wr,
  output logic [KEY_AW-1:0] Key_Addr,
  output logic              Init_ARK,
  output logic              En_InvFunc,
  output logic              Last_Rnd,
  output logic              Busy,
  output logic              Done
);
  localparam logic [KEY_AW-1:0] RK_LAST = KEY_AW'(NR);
  localparam logic [KEY_AW-1:0] RK_PEN  = KEY_AW'(NR - 1);

  // Held as raw bits so unused encodings can be decoded and recovered.
  logic [2:0]        state_q, state_d;
  logic [KEY_AW-1:0] rnd_q, rnd_d;
  logic              key_valid_q, key_valid_d;

  always_comb begin
    state_d     = state_q;
    rnd_d       = rnd_q;
    key_valid_d = key_valid_q;
    case (state_q)
      ST_IDLE: begin
        rnd_d = '0;
        if (Valid) begin
          // A same-cycle invalidate must not let a stale schedule be reused.
          if (Key_Reuse && key_valid_q && !Key_Inval) state_d = ST_INIT_ARK;
          else                                        state_d = ST_KEY_EXP;
        end
      end
      ST_KEY_EXP: begin
        if (rnd_q == RK_LAST) begin
          state_d     = ST_INIT_ARK;
          rnd_d       = '0;
          key_valid_d = 1'b1;
        end else begin
          rnd_d = rnd_q + 1'b1;
        end
      end
      ST_INIT_ARK: begin
        state_d = ST_INV_RND;
        rnd_d   = RK_PEN;
      end
      ST_INV_RND: begin
        if (rnd_q == KEY_AW'(1)) begin
          state_d = ST_LAST_RND;
          rnd_d   = '0;
        end else begin
          rnd_d = rnd_q - 1'b1;
        end
      end
      ST_LAST_RND: begin
        state_d = ST_FINISH;
        rnd_d   = '0;
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
        rnd_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        rnd_d   = '0;
      end
    endcase
    if (Key_Inval) key_valid_d = 1'b0;
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rnd_q       <= '0;
      key_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rnd_q       <= rnd_d;
      key_valid_q <= key_valid_d;
    end
  end

  always_comb begin
    En_KeyExp  = 1'b0;
    Key_Wr     = 1'b0;
    Key_Addr   = '0;
    Init_ARK   = 1'b0;
    En_InvFunc = 1'b0;
    Last_Rnd   = 1'b0;
    Busy       = 1'b0;
    Done       = 1'b0;
    case (state_q)
      ST_KEY_EXP: begin
        // Round 0 is the cipher key itself; expansion only advances from round 1.
        En_KeyExp = (rnd_q != '0);
        Key_Wr    = 1'b1;
        Key_Addr  = rnd_q;
        Busy      = 1'b1;
      end
      ST_INIT_ARK: begin
        Init_ARK = 1'b1;
        Key_Addr = RK_LAST;
        Busy     = 1'b1;
      end
      ST_INV_RND: begin
        En_InvFunc = 1'b1;
        Key_Addr   = rnd_q;
        Busy       = 1'b1;
      end
      ST_LAST_RND: begin
        En_InvFunc = 1'b1;
        Last_Rnd   = 1'b1;
        Busy       = 1'b1;
      end
      ST_FINISH: Done = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_inv_cipher_fsm.sv
// Directed bench for inv_cipher_fsm: cycle-by-cycle output traces for expansion, reuse,
// invalidation, back-to-back and mid-operation reset.
module tb_inv_cipher_fsm;
  logic       CLK = 1'b0;
  logic       rst_n;
  logic       Valid, Key_Reuse, Key_Inval;
  logic       En_KeyExp, Key_Wr, Init_ARK, En_InvFunc, Last_Rnd, Busy, Done;
  logic [3:0] Key_Addr;

  int total = 0;
  int bad   = 0;

  inv_cipher_fsm dut (
    .CLK(CLK), .rst_n(rst_n), .Valid(Valid), .Key_Reuse(Key_Reuse), .Key_Inval(Key_Inval),
    .En_KeyExp(En_KeyExp), .Key_Wr(Key_Wr), .Key_Addr(Key_Addr), .Init_ARK(Init_ARK),
    .En_InvFunc(En_InvFunc), .Last_Rnd(Last_Rnd), .Busy(Busy), .Done(Done)
  );

  always #5 CLK = ~CLK;

  // {En_KeyExp, Key_Wr, Key_Addr, Init_ARK, En_InvFunc, Last_Rnd, Busy, Done}
  function automatic logic [10:0] outs();
    return {En_KeyExp, Key_Wr, Key_Addr, Init_ARK, En_InvFunc, Last_Rnd, Busy, Done};
  endfunction

  // Expected outputs k cycles after the accepting edge (k=1 is the first cycle).
  function automatic logic [10:0] exp_out(input int k, input bit expand);
    int j;
    if (expand && k >= 1 && k <= 11)
      return {(k > 1), 1'b1, 4'(k - 1), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    j = expand ? k - 11 : k;
    if (j == 1)              return {1'b0, 1'b0, 4'd10, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    if (j >= 2 && j <= 10)   return {1'b0, 1'b0, 4'(11 - j), 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    if (j == 11)             return {1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    if (j == 12)             return 11'b000_0000_0001;
    return '0;
  endfunction

  // Start an op and trace it; optionally pulse Key_Inval at the edge after cycle inval_k.
  task automatic run_op(input string name, input bit reuse, input bit expand, input int inval_k);
    int lat, done_at, busy_n;
    lat = expand ? 23 : 12;
    done_at = 0; busy_n = 0;
    @(negedge CLK);
    Valid = 1'b1; Key_Reuse = reuse;
    @(negedge CLK);
    Valid = 1'b0; Key_Reuse = 1'b0;
    for (int k = 1; k <= lat + 1; k++) begin
      total++;
      if (outs() !== exp_out(k, expand)) begin
        bad++;
        $display("FAIL %s cycle %0d: got %b expected %b", name, k, outs(), exp_out(k, expand));
      end
      if (Done === 1'b1 && done_at == 0) done_at = k;
      if (Busy === 1'b1) busy_n++;
      Key_Inval = (k == inval_k);
      @(negedge CLK);
    end
    Key_Inval = 1'b0;
    total++;
    if (done_at != lat || busy_n != lat - 1) begin
      bad++;
      $display("FAIL %s latency: done at %0d busy %0d, expected %0d / %0d", name, done_at, busy_n, lat, lat - 1);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; Valid = 1'b0; Key_Reuse = 1'b0; Key_Inval = 1'b0;
    repeat (3) @(negedge CLK);
    total++;
    if (outs() !== 11'd0) begin
      bad++;
      $display("FAIL reset outputs: got %b expected 0", outs());
    end
    rst_n = 1'b1;
    repeat (2) @(negedge CLK);
    total++;
    if (outs() !== 11'd0) begin
      bad++;
      $display("FAIL idle outputs: got %b expected 0", outs());
    end
  endtask

  task automatic test_key_exp();
    run_op("expand", 1'b0, 1'b1, 0);
  endtask

  task automatic test_reuse();
    run_op("reuse", 1'b1, 1'b0, 0);
  endtask

  task automatic test_inval();
    // Reuse op; invalidate while in INV_RND (cycle 5), op must still complete.
    run_op("inval_cur", 1'b1, 1'b0, 5);
    run_op("inval_next", 1'b1, 1'b1, 0);
  endtask

  task automatic test_back_to_back();
    logic [10:0] e;
    int dones;
    dones = 0;
    @(negedge CLK);
    Valid = 1'b1; Key_Reuse = 1'b1;
    @(negedge CLK);
    for (int k = 1; k <= 26; k++) begin
      e = (k <= 12) ? exp_out(k, 1'b0) : (k == 13) ? 11'd0 : exp_out(k - 13, 1'b0);
      total++;
      if (outs() !== e) begin
        bad++;
        $display("FAIL b2b cycle %0d: got %b expected %b", k, outs(), e);
      end
      if (Done === 1'b1) dones++;
      if (k == 26) begin Valid = 1'b0; Key_Reuse = 1'b0; end
      @(negedge CLK);
    end
    total++;
    if (dones != 2 || outs() !== 11'd0) begin
      bad++;
      $display("FAIL b2b done count: got %0d expected 2, outs %b", dones, outs());
    end
  endtask

  task automatic test_reset_mid();
    @(negedge CLK);
    Valid = 1'b1; Key_Reuse = 1'b1;
    @(negedge CLK);
    Valid = 1'b0; Key_Reuse = 1'b0;
    repeat (5) @(negedge CLK);
    total++;
    if (outs() !== exp_out(6, 1'b0)) begin
      bad++;
      $display("FAIL pre_reset rnd5: got %b expected %b", outs(), exp_out(6, 1'b0));
    end
    #1 rst_n = 1'b0;
    #1;
    total++;
    if (outs() !== 11'd0) begin
      bad++;
      $display("FAIL async reset: got %b expected 0", outs());
    end
    @(negedge CLK);
    rst_n = 1'b1;
    run_op("post_reset", 1'b1, 1'b1, 0);
  endtask

  initial begin
    test_reset();
    test_key_exp();
    test_reuse();
    test_inval();
    run_op("reuse_again", 1'b1, 1'b0, 0);
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/inv_cipher_fsm.md
INV_CIPHER_FSM -- requirements
Module: inv_cipher_fsm

Interface
REQ-001 SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port Valid, input, 1 bit: start request; sampled only in IDLE.
REQ-004 SHALL have port Key_Reuse, input, 1 bit: skip key expansion if the stored schedule is valid; sampled with Valid.
REQ-005 SHALL have port Key_Inval, input, 1 bit: pulse; the cipher key register has changed.
REQ-006 SHALL have port En_KeyExp, output, 1 bit: advance forward key expansion one round.
REQ-007 SHALL have port Key_Wr, output, 1 bit: write the current round key to key store at Key_Addr.
REQ-008 SHALL have port Key_Addr, output, 4 bits: key store address, 0..10.
REQ-009 SHALL have port Init_ARK, output, 1 bit: initial AddRoundKey with round key 10.
REQ-010 SHALL have port En_InvFunc, output, 1 bit: perform one inverse round.
REQ-011 SHALL have port Last_Rnd, output, 1 bit: final inverse round, no InvMixColumns.
REQ-012 SHALL have port Busy, output, 1 bit: operation in progress.
REQ-013 SHALL have port Done, output, 1 bit: one-cycle plaintext-ready pulse.

Function
REQ-014 SHALL implement states IDLE, KEY_EXP, INIT_ARK, INV_RND, LAST_RND, FINISH with registered state and a 4-bit round counter rnd.
REQ-015 IDLE: all outputs 0, rnd=0; Valid=1 -> INIT_ARK if Key_Reuse=1 and key_valid=1, else KEY_EXP; Valid=0 -> stay.
REQ-016 KEY_EXP: 11 cycles, rnd 0..10; Key_Wr=1, Key_Addr=rnd, En_KeyExp=1 only when rnd!=0, Busy=1; -> INIT_ARK after rnd=10.
REQ-017 INIT_ARK: 1 cycle; Init_ARK=1, Key_Addr=10, Busy=1; rnd loads 9; -> INV_RND.
REQ-018 INV_RND: 9 cycles, rnd 9 down to 1; En_InvFunc=1, Key_Addr=rnd, Busy=1; -> LAST_RND after rnd=1.
REQ-019 LAST_RND: 1 cycle; En_InvFunc=1, Last_Rnd=1, Key_Addr=0, Busy=1; -> FINISH.
REQ-020 FINISH: Done=1, Busy=0, other outputs 0; -> IDLE unconditionally.
REQ-021 Latency from the edge sampling Valid to the cycle Done=1: 23 cycles with expansion; 12 cycles with reuse.
REQ-022 Valid outside IDLE SHALL be ignored; there is no queuing. Valid in FINISH is not accepted; a new request is accepted one cycle later, in IDLE.
REQ-023 Internal flag key_valid SHALL be set at the edge leaving KEY_EXP (rnd=10).
REQ-024 key_valid SHALL be cleared at any edge where Key_Inval=1; clear SHALL win over a simultaneous set.
REQ-025 Key_Inval SHALL NOT abort an operation in progress.
REQ-026 Key_Inval=1 together with Valid=1 and Key_Reuse=1 in IDLE SHALL select KEY_EXP.
REQ-027 Key_Addr SHALL be 0 whenever no key access is signalled.
REQ-028 Illegal state encodings SHALL return to IDLE next cycle with outputs 0.
REQ-029 Outputs SHALL be decoded from current state and rnd only, as Moore outputs.

Reset
REQ-030 rst_n=0 SHALL immediately force state=IDLE, rnd=0, key_valid=0, all outputs 0, including mid-operation.
REQ-031 After reset the first accepted Valid SHALL always perform KEY_EXP regardless of Key_Reuse.

Structure
REQ-032 Shared package aes_pkg SHALL hold the state enum, NR=10, and the key-address width (4).
REQ-033 The block SHALL be a single module with no sub-modules; the round counter and key_valid are inline.

Verification
REQ-034 Reset, Valid pulse with Key_Reuse=0 -> KEY_EXP; Key_Wr with addresses 0..10; En_KeyExp on 10 cycles; INIT_ARK with Key_Addr=10; 9 INV_RND cycles with addresses 9..1; LAST_RND with Key_Addr=0; Done exactly 23 cycles after the Valid edge.
REQ-035 Second Valid with Key_Reuse=1 -> no Key_Wr; Done 12 cycles after Valid; Busy high for 11 cycles.
REQ-036 Key_Inval pulse during INV_RND, then Valid with Key_Reuse=1 -> current op completes normally; next op performs KEY_EXP (23-cycle latency).
REQ-037 Valid held high continuously -> back-to-back operations, each Done pulse 1 cycle wide, with one IDLE cycle between FINISH and the next start.
REQ-038 rst_n asserted at INV_RND rnd=5 -> all outputs 0 asynchronously; after release, Valid with Key_Reuse=1 still runs KEY_EXP.
